expected_in_accumulator: RTL and testbench

Sequential back-propagation target averager placed directly downstream of a learn layer. It accepts one neuron's `expected_in` row (N lanes) per handshake beat, accumulates per-lane sums over M rows, divides by M with a shared-cycle restoring divider, and presents the averaged N-lane vector to the preceding layer's `expected_out`. It trades the combinational M×N adder tree for M + W + 1 cycles of latency and one accumulator per lane.

---
 rtl/expected_in_accumulator_if.sv | 22 ++
 rtl/expected_in_accumulator.sv | 131 +++++++++++++
 tb/tb_expected_in_accumulator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/expected_in_accumulator_if.sv
// rtl/expected_in_accumulator_if.sv - row input and averaged output handshakes of expected_in_accumulator
interface expected_in_accumulator_if #(
    parameter int N = 16,
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_row;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_avg;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_avg
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_avg
    );
endinterface

// File: rtl/expected_in_accumulator.sv
// rtl/expected_in_accumulator.sv - averages M expected_in rows per lane via a shared-cycle restoring divide
// Optional EXPECTED_IN_ROUND_EN adds floor(M/2) before dividing for round-half-up averages.
module expected_in_accumulator #(
    parameter int N = 16,
    parameter int M = 55,
    parameter int W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    expected_in_accumulator_if.slave bus,
    output logic [$clog2(M+1)-1:0]   row_count,
    output logic                     busy
);
    localparam int S   = W + $clog2(M);
    localparam int RW  = $clog2(M) + 1;
    localparam int RCW = $clog2(M + 1);
    localparam int BW  = (W > 1) ? $clog2(W) : 1;

    localparam logic [RW:0]    DIVISOR  = (RW + 1)'(M);
    localparam logic [RCW-1:0] LAST_ROW = RCW'(M - 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(W - 1);

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

`ifdef EXPECTED_IN_ROUND_EN
    localparam logic [S-1:0] ROUND_BIAS = S'(M / 2);
`endif

    logic [1:0]    state;
    logic          loaded;
    logic [BW-1:0] bit_cnt;

    logic [S-1:0]  acc     [N];
    logic [RW-1:0] rem     [N];
    logic [W-1:0]  quot    [N];
    logic [S-1:0]  acc_add [N];
    logic [S-1:0]  acc_rnd [N];
    logic [RW:0]   trial   [N];
    logic [N-1:0]  ge;

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_DONE);
    assign busy          = (state != ST_ACCUM);

    for (genvar g = 0; g < N; g++) begin : g_lane_out
        assign bus.out_avg[g*W +: W] = quot[g];
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            acc_add[i] = acc[i] + S'(bus.in_row[i*W +: W]);
`ifdef EXPECTED_IN_ROUND_EN
            acc_rnd[i] = acc[i] + ROUND_BIAS;
`else
            acc_rnd[i] = acc[i];
`endif
            // Remainder stays below M, so one dividend bit shifted in never exceeds 2M.
            trial[i] = {rem[i], acc[i][W-1]};
            ge[i]    = (trial[i] >= DIVISOR);
        end
    end

    // DIVIDE spends one cycle seeding the remainder from sum >> W, then W quotient-bit cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_ACCUM;
            loaded    <= 1'b0;
            bit_cnt   <= '0;
            row_count <= '0;
            for (int i = 0; i < N; i++) begin
                acc[i]  <= '0;
                rem[i]  <= '0;
                quot[i] <= '0;
            end
        end else if (clear) begin
            state     <= ST_ACCUM;
            loaded    <= 1'b0;
            bit_cnt   <= '0;
            row_count <= '0;
            for (int i = 0; i < N; i++) begin
                acc[i] <= '0;
                rem[i] <= '0;
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) acc[i] <= acc_add[i];
                        row_count <= row_count + RCW'(1);
                        if (row_count == LAST_ROW) state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (!loaded) begin
                        loaded <= 1'b1;
                        for (int i = 0; i < N; i++) begin
                            acc[i] <= acc_rnd[i];
                            rem[i] <= RW'(acc_rnd[i] >> W);
                        end
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            rem[i]  <= ge[i] ? RW'(trial[i] - DIVISOR) : RW'(trial[i]);
                            acc[i]  <= acc[i] << 1;
                            quot[i] <= {quot[i][W-2:0], ge[i]};
                        end
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state   <= ST_DONE;
                            loaded  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state     <= ST_ACCUM;
                        row_count <= '0;
                        for (int i = 0; i < N; i++) begin
                            acc[i] <= '0;
                            rem[i] <= '0;
                        end
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_expected_in_accumulator.sv
// tb/tb_expected_in_accumulator.sv - directed bench for expected_in_accumulator (N=4, M=55, W=8)
module tb_expected_in_accumulator;
    localparam int N = 4;
    localparam int M = 55;
    localparam int W = 8;

    logic       clock;
    logic       reset_n;
    logic       clear;
    logic [5:0] row_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    expected_in_accumulator_if #(.N(N), .W(W)) ifc ();

    expected_in_accumulator #(.N(N), .M(M), .W(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .bus       (ifc),
        .row_count (row_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_rows(input logic [31:0] row, input int n);
        for (int k = 0; k < n; k++) begin
            ifc.in_valid = 1'b1;
            ifc.in_row   = row;
            step();
        end
        ifc.in_valid = 1'b0;
        ifc.in_row   = '0;
    endtask

    task automatic wait_valid(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (!ifc.out_valid && cnt < 50) begin
            step();
            cnt++;
        end
        check(tag, 64'(cnt), 64'(exp_cycles));
    endtask

    task automatic take_output(input string tag);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        check({tag, "_valid_low"}, 64'(ifc.out_valid), 64'd0);
        check({tag, "_ready_high"}, 64'(ifc.in_ready), 64'd1);
        check({tag, "_rows_zero"}, 64'(row_count), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] round_exp;
        int          late_valid;

        reset_n       = 1'b0;
        clear         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_row    = '0;
        ifc.out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_out_avg", 64'(ifc.out_avg), 64'd0);
        check("rst_row_count", 64'(row_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // All-ones batch with latency and post-accept flags
        send_rows(32'hFFFF_FFFF, M);
        check("ones_rows", 64'(row_count), 64'd55);
        check("ones_in_ready", 64'(ifc.in_ready), 64'd0);
        check("ones_busy", 64'(busy), 64'd1);
        wait_valid("ones_latency", 9);
        check("ones_avg", 64'(ifc.out_avg), 64'hFFFF_FFFF);
        take_output("ones_take");

        // Mixed lanes {1,0,100,200}, then backpressure with junk input
        send_rows(32'hC864_0001, M);
        wait_valid("mixed_latency", 9);
        check("mixed_avg", 64'(ifc.out_avg), 64'hC864_0001);
        held = ifc.out_avg;
        for (int k = 0; k < 10; k++) begin
            ifc.in_valid = 1'b1;
            ifc.in_row   = 32'hDEAD_BEEF ^ 32'(k);
            step();
            check("bp_avg_stable", 64'(ifc.out_avg), 64'(held));
            check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
            check("bp_rows", 64'(row_count), 64'd55);
            check("bp_valid", 64'(ifc.out_valid), 64'd1);
        end
        ifc.in_valid = 1'b0;
        take_output("bp_take");

        // Rounding: lane0 sums to 54 over 55 rows
`ifdef EXPECTED_IN_ROUND_EN
        round_exp = 32'h0000_0001;
`else
        round_exp = 32'h0000_0000;
`endif
        send_rows(32'h0000_0036, 1);
        send_rows(32'h0000_0000, M - 1);
        wait_valid("round_latency", 9);
        check("round_avg", 64'(ifc.out_avg), 64'(round_exp));
        take_output("round_take");

        // Clear mid-batch drops 20 rows of 7 plus the row in the clear cycle
        send_rows(32'h0707_0707, 20);
        check("clr_rows_before", 64'(row_count), 64'd20);
        clear        = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_row   = 32'h0707_0707;
        step();
        clear        = 1'b0;
        ifc.in_valid = 1'b0;
        check("clr_rows_after", 64'(row_count), 64'd0);
        check("clr_in_ready", 64'(ifc.in_ready), 64'd1);
        send_rows(32'h0A0A_0A0A, M);
        wait_valid("clr_latency", 9);
        check("clr_avg", 64'(ifc.out_avg), 64'h0A0A_0A0A);
        take_output("clr_take");

        // Async reset three cycles into the divide
        send_rows(32'hFFFF_FFFF, M);
        step();
        step();
        step();
        check("ar_busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(ifc.out_valid), 64'd0);
        check("ar_out_avg", 64'(ifc.out_avg), 64'd0);
        check("ar_in_ready", 64'(ifc.in_ready), 64'd1);
        check("ar_rows", 64'(row_count), 64'd0);
        step();
        reset_n = 1'b1;
        late_valid = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ifc.out_valid) late_valid++;
        end
        check("ar_no_output", 64'(late_valid), 64'd0);
        check("ar_avg_zero", 64'(ifc.out_avg), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
